can_tx_serializer: RTL

Transmit-side bit engine for the SJA1000-style CAN controller. It turns a standard-format (11-bit ID) CAN 2.0A frame request into the serial bus bit stream: arbitration, control, data, CRC-15, delimiters, ACK slot, EOF and intermission. It inserts stuff bits and detects arbitration loss and ACK errors. It is driven by the bit-timing logic's tx_point/sample_point strobes. Frame fields come from the TX buffer registers, which are built from can_register instances.

---
 rtl/can_tx_serializer_pkg.sv | 32 +++
 rtl/can_tx_serializer_crc15.sv | 23 ++
 rtl/can_tx_serializer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/can_tx_serializer_pkg.sv
// Shared definitions for the CAN transmit path: frame states, field lengths
// and the CRC-15 step function.
package can_tx_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        ARB       = 4'd1,
        CTRL      = 4'd2,
        DATA      = 4'd3,
        CRC       = 4'd4,
        CRC_DELIM = 4'd5,
        ACK_SLOT  = 4'd6,
        ACK_DELIM = 4'd7,
        EOF       = 4'd8,
        IFS       = 4'd9
    } state_t;

    localparam logic [14:0] CRC15_POLY = 15'h4599;

    localparam int ID_LEN  = 11;
    localparam int DLC_LEN = 4;
    localparam int CRC_LEN = 15;
    localparam int EOF_LEN = 7;
    localparam int IFS_LEN = 3;

    function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic data_bit);
        logic [14:0] shifted;
        shifted = {crc[13:0], 1'b0};
        return (data_bit ^ crc[14]) ? (shifted ^ CRC15_POLY) : shifted;
    endfunction

endpackage

// File: rtl/can_tx_serializer_crc15.sv
// Serial CRC-15 accumulator, one bit per enable; shared with the receive path.
module can_crc15
    import can_tx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        enable,
    input  logic        data_bit,
    output logic [14:0] crc
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            crc <= 15'd0;
        end else if (init) begin
            crc <= 15'd0;
        end else if (enable) begin
            crc <= crc15_step(crc, data_bit);
        end
    end

endmodule

// File: rtl/can_tx_serializer.sv
// CAN 2.0A transmit bit engine: serialises a standard frame with bit stuffing,
// CRC-15, arbitration-loss and ACK-error detection.
module can_tx_serializer
    import can_tx_pkg::*;
#(
    parameter int DATA_BYTES = 8,
    parameter int STUFF_LEN  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_point,
    input  logic        sample_point,
    input  logic        rx,
    input  logic        tx_request,
    input  logic [10:0] tx_id,
    input  logic        tx_rtr,
    input  logic [3:0]  tx_dlc,
    input  logic [63:0] tx_data,
    output logic        tx_o,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        arb_lost,
    output logic        ack_err
);

    localparam logic [3:0] MAX_BYTES = 4'(DATA_BYTES);
    localparam logic [3:0] STUFF_RUN = 4'(STUFF_LEN);

    state_t      state;
    state_t      nxt_state;
    logic [6:0]  cnt;
    logic [10:0] id_q;
    logic        rtr_q;
    logic [3:0]  dlc_q;
    logic [63:0] data_q;
    logic [6:0]  data_bits;
    logic        last_lvl;
    logic [3:0]  run_len;
    logic        arb_bit;
    logic        ack_bit;

    logic [14:0] crc;
    logic        crc_init;
    logic        crc_en;
    logic        nxt_bit;
    logic        field_last;
    logic        stuff_zone;
    logic        crc_zone;
    logic        do_stuff;
    logic        tx_step;
    logic [3:0]  n_bytes;

    assign n_bytes    = tx_rtr ? 4'd0 : ((tx_dlc > MAX_BYTES) ? MAX_BYTES : tx_dlc);
    assign crc_zone   = (state == ARB) || (state == CTRL) || (state == DATA);
    // CRC_DELIM is included so a run ending on the last CRC bit still gets its stuff bit.
    assign stuff_zone = crc_zone || (state == CRC) || (state == CRC_DELIM);
    assign do_stuff   = stuff_zone && (run_len == STUFF_RUN);
    assign tx_step    = tx_point && !sample_point && (state != IDLE);
    assign crc_init   = (state == IDLE) && tx_request;
    assign crc_en     = tx_step && !do_stuff && crc_zone;

    can_crc15 u_crc (
        .clk      (clk),
        .rst      (rst),
        .init     (crc_init),
        .enable   (crc_en),
        .data_bit (nxt_bit),
        .crc      (crc)
    );

    // Bit at the current field position and the field that follows it.
    always_comb begin
        nxt_bit    = 1'b1;
        field_last = 1'b0;
        nxt_state  = state;
        case (state)
            ARB: begin
                if (cnt == 7'd0)              nxt_bit = 1'b0;
                else if (cnt <= 7'(ID_LEN))   nxt_bit = id_q[4'(ID_LEN) - cnt[3:0]];
                else                          nxt_bit = rtr_q;
                field_last = (cnt == 7'(ID_LEN + 1));
                nxt_state  = CTRL;
            end
            CTRL: begin
                nxt_bit    = (cnt >= 7'd2) ? dlc_q[2'(3'd5 - cnt[2:0])] : 1'b0;
                field_last = (cnt == 7'(DLC_LEN + 1));
                nxt_state  = (data_bits != 7'd0) ? DATA : CRC;
            end
            DATA: begin
                nxt_bit    = data_q[6'd63 - cnt[5:0]];
                field_last = (cnt == data_bits - 7'd1);
                nxt_state  = CRC;
            end
            CRC: begin
                nxt_bit    = crc[4'(CRC_LEN - 1) - cnt[3:0]];
                field_last = (cnt == 7'(CRC_LEN - 1));
                nxt_state  = CRC_DELIM;
            end
            CRC_DELIM: begin field_last = 1'b1; nxt_state = ACK_SLOT;  end
            ACK_SLOT:  begin field_last = 1'b1; nxt_state = ACK_DELIM; end
            ACK_DELIM: begin field_last = 1'b1; nxt_state = EOF;       end
            EOF: begin
                field_last = (cnt == 7'(EOF_LEN - 1));
                nxt_state  = IFS;
            end
            IFS: begin
                field_last = (cnt == 7'(IFS_LEN - 1));
                nxt_state  = IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 7'd0;
            tx_o     <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            arb_lost <= 1'b0;
            ack_err  <= 1'b0;
            last_lvl <= 1'b1;
            run_len  <= 4'd0;
            arb_bit  <= 1'b0;
            ack_bit  <= 1'b0;
        end else begin
            tx_done  <= 1'b0;
            arb_lost <= 1'b0;
            ack_err  <= 1'b0;
            if (state == IDLE) begin
                if (tx_request) begin
                    state    <= ARB;
                    cnt      <= 7'd0;
                    tx_busy  <= 1'b1;
                    last_lvl <= 1'b1;
                    run_len  <= 4'd0;
                    arb_bit  <= 1'b0;
                    ack_bit  <= 1'b0;
                end
            end else if (sample_point) begin
                if (arb_bit && tx_o && !rx) begin
                    arb_lost <= 1'b1;
                    state    <= IDLE;
                    tx_busy  <= 1'b0;
                    tx_o     <= 1'b1;
                end else if (ack_bit && rx) begin
                    ack_err  <= 1'b1;
                    state    <= IDLE;
                    tx_busy  <= 1'b0;
                    tx_o     <= 1'b1;
                end
            end else if (tx_step) begin
                arb_bit <= 1'b0;
                ack_bit <= 1'b0;
                if (do_stuff) begin
                    tx_o     <= ~last_lvl;
                    last_lvl <= ~last_lvl;
                    run_len  <= 4'd1;
                end else begin
                    tx_o    <= nxt_bit;
                    arb_bit <= (state == ARB) && (cnt != 7'd0);
                    ack_bit <= (state == ACK_SLOT);
                    if (crc_zone || state == CRC) begin
                        last_lvl <= nxt_bit;
                        run_len  <= (nxt_bit == last_lvl) ? run_len + 4'd1 : 4'd1;
                    end
                    if (field_last) begin
                        state <= nxt_state;
                        cnt   <= 7'd0;
                        if (state == IFS) begin
                            tx_done <= 1'b1;
                            tx_busy <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && tx_request) begin
            id_q      <= tx_id;
            rtr_q     <= tx_rtr;
            dlc_q     <= tx_dlc;
            data_q    <= tx_data;
            data_bits <= {n_bytes, 3'b000};
        end
    end

endmodule
